clk_div_prog: RTL and testbench

//  Programmable integer clock divider. Parametrised successor of the fixed /4 divider.

---
 rtl/clk_div_pkg.sv | 17 +
 rtl/clk_div_core.sv | 56 +++++
 rtl/clk_div_prog.sv | 86 ++++++++
 tb/tb_clk_div_prog.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared widths, legacy /4 defaults and the config validity rule.
// Rev 1.0
`default_nettype none

package clk_div_pkg;

  localparam int CNT_W_DEFAULT = 16;
  localparam int LEGACY_DIV    = 4;
  localparam int LEGACY_LOW    = 2;

  function automatic logic cfg_is_valid(input logic [31:0] div, input logic [31:0] low);
    return (div != 32'd0) && (low <= div);
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_core.sv
// clk_div_core: phase counter plus registered out/tick, driven by the ratio/duty in force.
// Rev 1.0
`default_nettype none

module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] div_cur,
  input  logic [CNT_W-1:0] div_nxt,
  input  logic [CNT_W-1:0] low_nxt,
  output logic             wrap,
  output logic [CNT_W-1:0] cnt,
  output logic             out,
  output logic             tick
);

  logic             last;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    last     = (cnt == div_cur - CNT_W'(1));
    cnt_next = cnt;
    if (clr) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = last ? '0 : cnt + CNT_W'(1);
    end
  end

  assign wrap = en & last;

  // out/tick are derived from the next phase and the ratio in force after this edge,
  // so they move on the same edge as cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      out  <= 1'b0;
      tick <= 1'b0;
    end else if (clr || en) begin
      cnt  <= cnt_next;
      out  <= (cnt_next >= low_nxt);
      tick <= (cnt_next == div_nxt - CNT_W'(1));
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable integer divider with shadowed ratio/duty applied at period boundaries.
// Rev 1.0
`default_nettype none

module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int DEFAULT_DIV = LEGACY_DIV,
  parameter int DEFAULT_LOW = LEGACY_LOW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_low,
  output logic             cfg_err,
  output logic             out,
  output logic             tick,
  output logic [CNT_W-1:0] cnt_o
);

  logic             pending;
  logic [CNT_W-1:0] sh_div;
  logic [CNT_W-1:0] sh_low;
  logic [CNT_W-1:0] act_div;
  logic [CNT_W-1:0] act_low;
  logic             wrap;
  logic             xfer;
  logic             req_ok;
  logic             apply;
  logic [CNT_W-1:0] div_nxt;
  logic [CNT_W-1:0] low_nxt;

  assign cfg_ready = ~pending;
  assign xfer      = cfg_valid & cfg_ready;
  assign req_ok    = cfg_is_valid(32'(cfg_div), 32'(cfg_low));
  // A transfer cannot coincide with an apply: apply needs a pending shadow, which blocks ready.
  assign apply     = pending & (sync_clr | wrap);
  assign div_nxt   = apply ? sh_div : act_div;
  assign low_nxt   = apply ? sh_low : act_low;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      sh_div  <= '0;
      sh_low  <= '0;
      act_div <= CNT_W'(DEFAULT_DIV);
      act_low <= CNT_W'(DEFAULT_LOW);
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= xfer & ~req_ok;
      if (apply) begin
        act_div <= sh_div;
        act_low <= sh_low;
        pending <= 1'b0;
      end else if (xfer && req_ok) begin
        sh_div  <= cfg_div;
        sh_low  <= cfg_low;
        pending <= 1'b1;
      end
    end
  end

  clk_div_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clr     (sync_clr),
    .div_cur (act_div),
    .div_nxt (div_nxt),
    .low_nxt (low_nxt),
    .wrap    (wrap),
    .cnt     (cnt_o),
    .out     (out),
    .tick    (tick)
  );

endmodule

`default_nettype wire

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed and random stimulus against a period/phase reference model.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_clk_div_prog;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        sync_clr;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_div;
  logic [15:0] cfg_low;
  logic        cfg_err;
  logic        out;
  logic        tick;
  logic [15:0] cnt_o;

  int unsigned n_checks;
  int unsigned n_errors;

  // Reference model: position within the period, ratio/duty in force, one-deep request slot.
  int unsigned m_phase, m_div, m_low, m_sdiv, m_slow;
  bit          m_pend, m_err, m_active;

  clk_div_prog dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sync_clr  (sync_clr),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_low   (cfg_low),
    .cfg_err   (cfg_err),
    .out       (out),
    .tick      (tick),
    .cnt_o     (cnt_o)
  );

  initial clk = 1'b0;
  always #2500 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_div    = 4;
    m_low    = 2;
    m_pend   = 0;
    m_err    = 0;
    m_active = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".cnt"},   32'(cnt_o),     m_phase);
    check({tag, ".out"},   32'(out),       32'(m_phase >= m_low));
    check({tag, ".tick"},  32'(tick),      32'(m_active && (m_phase == m_div - 1)));
    check({tag, ".ready"}, 32'(cfg_ready), 32'(!m_pend));
    check({tag, ".err"},   32'(cfg_err),   32'(m_err));
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic step(input string tag);
    bit xfer, ok, apply;
    xfer  = cfg_valid && !m_pend;
    ok    = (cfg_div >= 1) && (cfg_low <= cfg_div);
    apply = 0;
    @(posedge clk);
    m_err = xfer && !ok;
    if (sync_clr) begin
      m_phase  = 0;
      apply    = m_pend;
      m_active = 1;
    end else if (en) begin
      if (m_phase == m_div - 1) begin
        m_phase = 0;
        apply   = m_pend;
      end else begin
        m_phase++;
      end
      m_active = 1;
    end else begin
      m_active = 0;
    end
    if (apply) begin
      m_div  = m_sdiv;
      m_low  = m_slow;
      m_pend = 0;
    end else if (xfer && ok) begin
      m_sdiv = cfg_div;
      m_slow = cfg_low;
      m_pend = 1;
    end
    #1;
    check_all(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic request(input string tag, input int d, input int l);
    cfg_valid = 1'b1;
    cfg_div   = 16'(d);
    cfg_low   = 16'(l);
    step(tag);
    cfg_valid = 1'b0;
  endtask

  task automatic run_to_phase(input string tag, input int unsigned ph);
    int guard;
    guard = 0;
    while (m_phase != ph && guard < 100) begin
      step(tag);
      guard++;
    end
    check({tag, ".reach"}, m_phase, ph);
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1;
    check_all(tag);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    en        = 1'b0;
    sync_clr  = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    cfg_low   = '0;
    model_reset();
    #1;
    check_all("reset");
    #9999;
    check_all("reset_hold");
    rst_n = 1'b1;
    en    = 1'b1;

    run("legacy", 12);

    run_to_phase("mid", 1);
    request("cfg5_2", 5, 2);
    run("div5", 15);

    request("bad_div0", 0, 0);
    run("after_bad0", 3);
    request("bad_low", 5, 6);
    run("after_bad_low", 6);

    request("cfg1_0", 1, 0);
    run("div1", 8);
    request("cfg3_3", 3, 3);
    run("div3", 9);

    request("cfg4_2", 4, 2);
    run("back4", 6);
    run_to_phase("pre_freeze", 2);
    en = 1'b0;
    run("freeze", 7);
    en = 1'b1;
    run("resume", 5);

    run_to_phase("pre_clr", 0);
    request("cfg6_1", 6, 1);
    run_to_phase("clr_at1", 1);
    sync_clr = 1'b1;
    step("sync_clr");
    sync_clr = 1'b0;
    run("div6", 8);

    run_to_phase("pre_rst", 3);
    request("cfg7_3", 7, 3);
    pulse_reset("mid_rst");
    run("post_rst", 10);

    // Random mix of enable gaps, restarts and good/bad requests.
    for (int i = 0; i < 800; i++) begin
      int d;
      en        = ($urandom_range(0, 9) != 0);
      sync_clr  = ($urandom_range(0, 29) == 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      d         = $urandom_range(0, 8);
      cfg_div   = 16'(d);
      cfg_low   = 16'($urandom_range(0, d + 1));
      step("rand");
      if ($urandom_range(0, 299) == 0) pulse_reset("rand_rst");
    end
    en        = 1'b1;
    sync_clr  = 1'b0;
    cfg_valid = 1'b0;

    // Full-scale ratio: one complete period plus the wrap.
    run("settle", 10);
    request("cfg_max", 65535, 32768);
    sync_clr = 1'b1;
    step("max_clr");
    sync_clr = 1'b0;
    run("max", 65540);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
